// File: rtl/dff_reg.sv
// Parameterised-width D register with clock enable and synchronous active-high reset.
// Basic storage element for grok80 datapath and control registers; one cycle of latency.
module dff_reg #(
   parameter int unsigned          WIDTH       = 16,
   parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
   input  logic             clock,
   input  logic             async_reset,
   input  logic             enable,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Reset is sampled only on the clock edge despite the legacy port name; reset beats enable.
   always_ff @(posedge clock) begin
      if (async_reset) begin
         q <= RESET_VALUE;
      end else if (enable) begin
         q <= d;
      end
   end

endmodule

// File: tb/tb_dff_reg.sv
// Self-checking bench for dff_reg: 16-bit default, 1-bit and 32-bit instances sharing clock/reset/enable.
// Expected register values are queued when stimulus is driven and popped after the capturing edge.
module tb_dff_reg;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [15:0] d16;
   logic [0:0]  d1;
   logic [31:0] d32;
   logic [15:0] q16;
   logic [0:0]  q1;
   logic [31:0] q32;

   logic [15:0] sb16[$];
   logic [0:0]  sb1[$];
   logic [31:0] sb32[$];
   logic [15:0] exp16;
   logic [0:0]  exp1;
   logic [31:0] exp32;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dff_reg u16 (
      .clock(clk), .async_reset(rst), .enable(en), .d(d16), .q(q16)
   );

   dff_reg #(.WIDTH(1), .RESET_VALUE(1'b1)) u1 (
      .clock(clk), .async_reset(rst), .enable(en), .d(d1), .q(q1)
   );

   dff_reg #(.WIDTH(32), .RESET_VALUE(32'hDEADBEEF)) u32 (
      .clock(clk), .async_reset(rst), .enable(en), .d(d32), .q(q32)
   );

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; en = 1'b0; d16 = 16'h1234; d1 = 1'b0; d32 = 32'h0;
      sb16.push_back(16'h0000); sb1.push_back(1'b1); sb32.push_back(32'hDEADBEEF);
      tick();
      exp16 = sb16.pop_front(); checks++;
      if (q16 !== exp16) begin errors++; $display("FAIL reset_q16: got %h expected %h", q16, exp16); end
      exp1 = sb1.pop_front(); checks++;
      if (q1 !== exp1) begin errors++; $display("FAIL reset_q1: got %b expected %b", q1, exp1); end
      exp32 = sb32.pop_front(); checks++;
      if (q32 !== exp32) begin errors++; $display("FAIL reset_q32: got %h expected %h", q32, exp32); end
   endtask

   task automatic test_capture();
      @(negedge clk);
      rst = 1'b0; en = 1'b1; d16 = 16'hFFFF;
      sb16.push_back(16'hFFFF);
      tick();
      exp16 = sb16.pop_front(); checks++;
      if (q16 !== exp16) begin errors++; $display("FAIL capture: got %h expected %h", q16, exp16); end
      d16 = 16'h1111;
      @(negedge clk);
      #1;
      checks++;
      if (q16 !== 16'hFFFF) begin errors++; $display("FAIL capture_hold_between_edges: got %h expected ffff", q16); end
   endtask

   task automatic test_sync_reset();
      rst = 1'b1;
      #1;
      checks++;
      if (q16 !== 16'hFFFF) begin errors++; $display("FAIL reset_before_edge: got %h expected ffff", q16); end
      for (int i = 0; i < 3; i++) sb16.push_back(16'h0000);
      for (int i = 0; i < 3; i++) begin
         tick();
         exp16 = sb16.pop_front(); checks++;
         if (q16 !== exp16) begin errors++; $display("FAIL reset_held_edge%0d: got %h expected %h", i, q16, exp16); end
      end
      rst = 1'b0; en = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (q16 !== 16'h0000) begin errors++; $display("FAIL reset_release_no_edge: got %h expected 0000", q16); end
   endtask

   task automatic test_enable_gating();
      d16 = 16'hF42F; en = 1'b0;
      sb16.push_back(16'h0000); sb16.push_back(16'h0000);
      for (int i = 0; i < 2; i++) begin
         tick();
         exp16 = sb16.pop_front(); checks++;
         if (q16 !== exp16) begin errors++; $display("FAIL enable_gating_cycle%0d: got %h expected %h", i, q16, exp16); end
      end
   endtask

   task automatic test_enable_no_edge();
      #1;
      en = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if (q16 !== 16'h0000) begin errors++; $display("FAIL enable_without_edge: got %h expected 0000", q16); end
      sb16.push_back(16'hF42F);
      tick();
      exp16 = sb16.pop_front(); checks++;
      if (q16 !== exp16) begin errors++; $display("FAIL enable_next_edge: got %h expected %h", q16, exp16); end
   endtask

   task automatic test_reset_priority();
      @(negedge clk);
      rst = 1'b1; en = 1'b1; d16 = 16'hA5A5; d1 = 1'b0; d32 = 32'h0;
      sb16.push_back(16'h0000); sb1.push_back(1'b1); sb32.push_back(32'hDEADBEEF);
      tick();
      exp16 = sb16.pop_front(); checks++;
      if (q16 !== exp16) begin errors++; $display("FAIL priority_en1_q16: got %h expected %h", q16, exp16); end
      exp1 = sb1.pop_front(); checks++;
      if (q1 !== exp1) begin errors++; $display("FAIL priority_en1_q1: got %b expected %b", q1, exp1); end
      exp32 = sb32.pop_front(); checks++;
      if (q32 !== exp32) begin errors++; $display("FAIL priority_en1_q32: got %h expected %h", q32, exp32); end
      // Load a non-reset value so the enable=0 reset is observable.
      @(negedge clk);
      rst = 1'b0; en = 1'b1;
      sb16.push_back(16'hA5A5);
      tick();
      exp16 = sb16.pop_front(); checks++;
      if (q16 !== exp16) begin errors++; $display("FAIL priority_preload: got %h expected %h", q16, exp16); end
      @(negedge clk);
      rst = 1'b1; en = 1'b0;
      sb16.push_back(16'h0000);
      tick();
      exp16 = sb16.pop_front(); checks++;
      if (q16 !== exp16) begin errors++; $display("FAIL priority_en0: got %h expected %h", q16, exp16); end
   endtask

   task automatic test_width();
      @(negedge clk);
      rst = 1'b0; en = 1'b1; d32 = 32'h12345678; d1 = 1'b0;
      sb32.push_back(32'h12345678); sb1.push_back(1'b0);
      tick();
      exp32 = sb32.pop_front(); checks++;
      if (q32 !== exp32) begin errors++; $display("FAIL width32_load: got %h expected %h", q32, exp32); end
      exp1 = sb1.pop_front(); checks++;
      if (q1 !== exp1) begin errors++; $display("FAIL width1_load: got %b expected %b", q1, exp1); end
      // Walking one across all 32 bits, with the 1-bit instance toggling alongside.
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         d32 = 32'h1 << i; d1 = 1'(i % 2);
         sb32.push_back(32'h1 << i); sb1.push_back(1'(i % 2));
         tick();
         exp32 = sb32.pop_front(); checks++;
         if (q32 !== exp32) begin errors++; $display("FAIL width32_walk%0d: got %h expected %h", i, q32, exp32); end
         exp1 = sb1.pop_front(); checks++;
         if (q1 !== exp1) begin errors++; $display("FAIL width1_walk%0d: got %b expected %b", i, q1, exp1); end
      end
      @(negedge clk);
      rst = 1'b1;
      sb32.push_back(32'hDEADBEEF);
      tick();
      exp32 = sb32.pop_front(); checks++;
      if (q32 !== exp32) begin errors++; $display("FAIL width32_reset: got %h expected %h", q32, exp32); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] last;
      @(negedge clk);
      rst = 1'b0; en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         d16 = 16'($urandom);
         d32 = $urandom;
         sb16.push_back(d16); sb32.push_back(d32);
         @(negedge clk);
         exp16 = sb16.pop_front(); checks++;
         if (q16 !== exp16) begin errors++; $display("FAIL b2b_q16_%0d: got %h expected %h", i, q16, exp16); end
         exp32 = sb32.pop_front(); checks++;
         if (q32 !== exp32) begin errors++; $display("FAIL b2b_q32_%0d: got %h expected %h", i, q32, exp32); end
      end
      // Hold with enable low while d keeps changing.
      last = d16;
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         d16 = 16'($urandom);
         sb16.push_back(last);
         @(negedge clk);
         exp16 = sb16.pop_front(); checks++;
         if (q16 !== exp16) begin errors++; $display("FAIL hold_%0d: got %h expected %h", i, q16, exp16); end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; en = 1'b0; d16 = '0; d1 = '0; d32 = '0;
      test_reset();
      test_capture();
      test_sync_reset();
      test_enable_gating();
      test_enable_no_edge();
      test_reset_priority();
      test_width();
      test_back_to_back();
      checks++;
      if (sb16.size() + sb1.size() + sb32.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb16.size() + sb1.size() + sb32.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
